// File: rtl/huffman_encoder.sv
// Table-driven prefix-code packer: 4-bit symbols are looked up in a writable code
// table, packed MSB-first into an accumulator and emitted as OUT_W-bit words.
module huffman_encoder #(
    parameter int SYM_W   = 4,
    parameter int MAX_LEN = 10,
    parameter int LEN_W   = 4,
    parameter int OUT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SYM_W-1:0]   sym_in,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic               flush,
    input  logic               tbl_we,
    input  logic [SYM_W-1:0]   tbl_addr,
    input  logic [LEN_W-1:0]   tbl_len,
    input  logic [MAX_LEN-1:0] tbl_code,
    output logic [OUT_W-1:0]   out_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [4:0]         out_nbits,
    output logic               done,
    output logic               err
);
    localparam int ACC_W = OUT_W + MAX_LEN;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int DEPTH = 2 ** SYM_W;
    localparam logic [CNT_W-1:0] C_OUT_W   = CNT_W'(OUT_W);
    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Default codebook restored on every reset.
    function automatic logic [LEN_W-1:0] dflt_len(input int s);
        if (s == 0)       return LEN_W'(1);
        else if (s <= 4)  return LEN_W'(4);
        else if (s <= 8)  return LEN_W'(5);
        else if (s <= 12) return LEN_W'(6);
        else              return LEN_W'(10);
    endfunction

    function automatic logic [MAX_LEN-1:0] dflt_code(input int s);
        if (s == 0)       return MAX_LEN'(1);
        else if (s <= 4)  return MAX_LEN'(s - 1);
        else if (s <= 8)  return MAX_LEN'(8 + s - 5);
        else if (s <= 12) return MAX_LEN'(24 + s - 9);
        else              return MAX_LEN'(448 + s - 13);
    endfunction

    logic [1:0]         r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [LEN_W-1:0]   r_tlen  [DEPTH];
    logic [MAX_LEN-1:0] r_tcode [DEPTH];

    logic               w_fire;
    logic               w_accept;
    logic               w_bad;
    logic               w_last_fire;
    logic [LEN_W-1:0]   w_len;
    logic [LEN_W-1:0]   w_len_eff;
    logic [LEN_W-1:0]   w_pad;
    logic [MAX_LEN-1:0] w_code_m;
    logic [ACC_W-1:0]   w_code_top;
    logic [ACC_W-1:0]   w_acc_post;
    logic [ACC_W-1:0]   w_acc_next;
    logic [CNT_W-1:0]   w_cnt_post;
    logic [CNT_W-1:0]   w_cnt_next;

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_nbits = '0;
        case (r_state)
            ST_RUN: begin
                out_valid = (r_cnt >= C_OUT_W);
                out_nbits = 5'(OUT_W);
            end
            ST_FLUSH: begin
                out_valid = (r_cnt != '0);
                out_last  = (r_cnt <= C_OUT_W);
                out_nbits = (r_cnt <= C_OUT_W) ? 5'(r_cnt) : 5'(OUT_W);
            end
            default: ;
        endcase
    end

    assign out_word = r_acc[ACC_W-1 -: OUT_W];
    assign done     = (r_state == ST_DONE);
    assign err      = r_err;

    // Bits below cnt are always zero, so OR-ing the aligned code appends it and
    // the final partial word comes out zero-padded for free.
    always_comb begin
        w_fire      = out_valid & out_ready;
        w_last_fire = w_fire & (r_cnt <= C_OUT_W);
        sym_ready   = (r_state == ST_RUN) & ((r_cnt < C_OUT_W) | w_fire);
        w_accept    = sym_valid & sym_ready;
        w_len       = r_tlen[sym_in];
        w_bad       = (w_len == '0) || (w_len > C_MAX_LEN);
        w_len_eff   = w_bad ? '0 : w_len;
        w_code_m    = r_tcode[sym_in] & ~({MAX_LEN{1'b1}} << w_len_eff);
        w_pad       = C_MAX_LEN - w_len_eff;
        w_code_top  = {w_code_m, {OUT_W{1'b0}}} << w_pad;
        w_acc_post  = w_fire ? (r_acc << OUT_W) : r_acc;
        w_cnt_post  = !w_fire ? r_cnt : ((r_cnt > C_OUT_W) ? (r_cnt - C_OUT_W) : '0);
        w_acc_next  = w_acc_post | (w_accept ? (w_code_top >> w_cnt_post) : '0);
        w_cnt_next  = w_cnt_post + (w_accept ? CNT_W'(w_len_eff) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tlen[i]  <= dflt_len(i);
                r_tcode[i] <= dflt_code(i);
            end
        end else begin
            if (tbl_we) begin
                r_tlen[tbl_addr]  <= tbl_len;
                r_tcode[tbl_addr] <= tbl_code;
            end
            case (r_state)
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_next;
                    if (w_accept && w_bad) r_err <= 1'b1;
                    if (flush) r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_next;
                    if (r_cnt == '0 || w_last_fire) r_state <= ST_DONE;
                end
                default: begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_encoder.sv
// Bench for huffman_encoder: directed cases plus random traffic scored against a
// bit-queue model of the code stream.
module tb_huffman_encoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sym_in = '0;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic       flush = 1'b0;
    logic       tbl_we = 1'b0;
    logic [3:0] tbl_addr = '0;
    logic [3:0] tbl_len = '0;
    logic [9:0] tbl_code = '0;
    logic [15:0] out_word;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic [4:0] out_nbits;
    logic       done;
    logic       err;

    huffman_encoder dut (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .flush(flush), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_len(tbl_len),
        .tbl_code(tbl_code), .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_nbits(out_nbits), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] w;
        logic        last;
        logic [4:0]  nb;
    } wrd_t;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: codes as bit strings, stream as a queue of bits.
    string dflt_s [16] = '{"1", "0000", "0001", "0010", "0011", "01000", "01001", "01010",
                           "01011", "011000", "011001", "011010", "011011",
                           "0111000000", "0111000001", "0111000010"};
    int         mlen  [16];
    logic [9:0] mcode [16];
    bit         bq [$];
    wrd_t       ew [$];
    wrd_t       got_q [$];
    logic       merr;
    int         mode;     // 0 streaming, 1 draining after flush
    int         cyc = 0;
    int         done_at = -1;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mlen[i]  = dflt_s[i].len();
            mcode[i] = '0;
            for (int j = 0; j < dflt_s[i].len(); j++)
                mcode[i] = {mcode[i][8:0], (dflt_s[i][j] == "1")};
        end
        bq.delete();
        ew.delete();
        merr    = 1'b0;
        mode    = 0;
        done_at = -1;
    endtask

    task automatic take_word(input int n, input logic last);
        wrd_t t;
        t.w = '0;
        for (int i = 0; i < 16; i++) t.w = {t.w[14:0], (i < n) ? logic'(bq.pop_front()) : 1'b0};
        t.last = last;
        t.nb   = 5'(n);
        ew.push_back(t);
    endtask

    task automatic model_step();
        logic was_run, in_done;
        wrd_t f;
        was_run = (mode == 0);
        in_done = (mode == 1) && (cyc == done_at);
        chk("out_valid", 32'(out_valid), 32'(!in_done && ew.size() > 0));
        chk("sym_ready", 32'(sym_ready), 32'(mode == 0 && (ew.size() == 0 || out_ready)));
        chk("done", 32'(done), 32'(in_done));
        chk("err", 32'(err), 32'(merr));
        if (out_valid && ew.size() > 0) begin
            chk("out_word", 32'(out_word), 32'(ew[0].w));
            chk("out_last", 32'(out_last), 32'(ew[0].last));
            chk("out_nbits", 32'(out_nbits), 32'(ew[0].nb));
        end
        if (out_valid && out_ready) begin
            f.w = out_word; f.last = out_last; f.nb = out_nbits;
            got_q.push_back(f);
            if (ew.size() > 0) begin
                f = ew.pop_front();
                if (mode == 1 && f.last) done_at = cyc + 1;
            end
        end
        if (in_done) mode = 0;
        if (sym_valid && sym_ready) begin
            if (mlen[sym_in] == 0 || mlen[sym_in] > 10) merr = 1'b1;
            else for (int b = mlen[sym_in] - 1; b >= 0; b--) bq.push_back(mcode[sym_in][b]);
            while (bq.size() >= 16) take_word(16, 1'b0);
        end
        if (flush && was_run) begin
            if (bq.size() > 0) take_word(bq.size(), 1'b1);
            else if (ew.size() > 0) begin
                f = ew.pop_back();
                f.last = 1'b1;
                ew.push_back(f);
            end
            mode = 1;
            if (ew.size() == 0) done_at = cyc + 2;
        end
        if (tbl_we) begin
            mlen[tbl_addr]  = int'(tbl_len);
            mcode[tbl_addr] = tbl_code;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) model_reset();
        else model_step();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [3:0] s);
        int n;
        logic ok;
        n = 0;
        ok = 1'b0;
        sym_in = s;
        sym_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = sym_ready;
            step();
            n++;
        end
        sym_valid = 1'b0;
        chk("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic tbl_write(input logic [3:0] a, input logic [3:0] l, input logic [9:0] c);
        tbl_we = 1'b1; tbl_addr = a; tbl_len = l; tbl_code = c;
        step();
        tbl_we = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            seen = done;
            step();
            n++;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    function automatic wrd_t got_at(input int i);
        wrd_t d;
        d.w = 16'hDEAD; d.last = 1'b0; d.nb = 5'd31;
        if (i < got_q.size()) return got_q[i];
        return d;
    endfunction

    initial begin
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sym_ready", 32'(sym_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        step();

        // 1: sixteen s0 at full rate
        got_q.delete();
        repeat (16) send_sym(4'd0);
        repeat (3) step();
        chk("t1_count", got_q.size(), 1);
        chk("t1_word", 32'(got_at(0).w), 32'hFFFF);
        chk("t1_nbits", 32'(got_at(0).nb), 32'd16);
        chk("t1_last", 32'(got_at(0).last), 32'd0);

        // 2: s13 s1 s5 then flush
        got_q.delete();
        send_sym(4'd13); send_sym(4'd1); send_sym(4'd5);
        flush_pulse();
        wait_done();
        chk("t2_count", got_q.size(), 2);
        chk("t2_w0", 32'(got_at(0).w), 32'h7001);
        chk("t2_l0", 32'(got_at(0).last), 32'd0);
        chk("t2_w1", 32'(got_at(1).w), 32'h0000);
        chk("t2_nb1", 32'(got_at(1).nb), 32'd3);
        chk("t2_l1", 32'(got_at(1).last), 32'd1);

        // 3: backpressure, then fire and accept together
        got_q.delete();
        out_ready = 1'b0;
        send_sym(4'd13); send_sym(4'd13);
        sym_in = 4'd1; sym_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_stall_ready", 32'(sym_ready), 32'd0);
            chk("t3_stall_word", 32'(out_word), 32'h701C);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_fire_ready", 32'(sym_ready), 32'd1);
        step();
        sym_valid = 1'b0;
        flush_pulse();
        wait_done();
        chk("t3_count", got_q.size(), 2);
        chk("t3_w0", 32'(got_at(0).w), 32'h701C);
        chk("t3_w1", 32'(got_at(1).w), 32'h0000);
        chk("t3_nb1", 32'(got_at(1).nb), 32'd8);

        // 4: rewrite s0, then a zero-length entry
        got_q.delete();
        tbl_write(4'd0, 4'd2, 10'b10);
        repeat (8) send_sym(4'd0);
        repeat (3) step();
        chk("t4_count", got_q.size(), 1);
        chk("t4_word", 32'(got_at(0).w), 32'hAAAA);
        tbl_write(4'd0, 4'd0, 10'd0);
        send_sym(4'd0);
        @(negedge clk);
        chk("t4_err", 32'(err), 32'd1);
        step();

        // 5: flush with empty accumulator
        got_q.delete();
        flush_pulse();
        wait_done();
        @(negedge clk);
        chk("t5_ready_after", 32'(sym_ready), 32'd1);
        step();
        chk("t5_count", got_q.size(), 0);

        // 6: reset mid-stream
        send_sym(4'd1); send_sym(4'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_sym_ready", 32'(sym_ready), 32'd1);
        step();
        got_q.delete();
        tbl_write(4'd2, 4'd11, 10'h3FF);
        send_sym(4'd2);
        repeat (16) send_sym(4'd0);
        repeat (3) step();
        chk("t6_err_long", 32'(err), 32'd1);
        chk("t6_count", got_q.size(), 1);
        chk("t6_word", 32'(got_at(0).w), 32'hFFFF);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = (i == 1500);
            sym_valid = ($urandom_range(0, 3) != 0);
            sym_in    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            tbl_we    = ($urandom_range(0, 29) == 0);
            tbl_addr  = 4'($urandom_range(0, 15));
            tbl_len   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15))
                                                    : 4'($urandom_range(1, 10));
            tbl_code  = 10'($urandom_range(0, 1023));
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0; sym_valid = 1'b0; tbl_we = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (60) step();
        flush_pulse();
        wait_done();
        step();
        chk("final_drain", ew.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
